pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable,

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates data-memory
// wait states, EX-stage redirects and load-use hazards into pipeline-register controls.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wn,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_kill,
  output logic        dmem_req,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MEM      = 2'd1,
    CAUSE_REDIRECT = 2'd2,
    CAUSE_LOADUSE  = 2'd3
  } cause_e;

  // Last wait_cnt value tolerated in MEM_WAIT before declaring a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic   load_use;
  logic   mem_stall;
  cause_e cause;

  // Hazard detection and priority arbitration.
  always_comb begin
    load_use  = ex_memread && (ex_wn != 5'd0) &&
                ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));
    mem_stall = !dmem_ready &&
                (((state_q == RUN) && mem_access) || (state_q == MEM_WAIT));

    cause = CAUSE_NONE;
    if (mem_stall) begin
      cause = CAUSE_MEM;
    end else if (ex_redirect) begin
      cause = CAUSE_REDIRECT;
    end else if (load_use) begin
      cause = CAUSE_LOADUSE;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_kill = 1'b0;
    dmem_req   = 1'b0;

    // While reset is held the pipeline sees idle controls whatever the state.
    if (rst_n) begin
      case (state_q)
        ERR: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          memwb_kill = 1'b1;
        end
        default: begin
          dmem_req = (state_q == MEM_WAIT) || mem_access;
          case (cause)
            CAUSE_MEM: begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_en    = 1'b0;
              exmem_en   = 1'b0;
              memwb_kill = 1'b1;
            end
            CAUSE_REDIRECT: begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end
            CAUSE_LOADUSE: begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Wait-state FSM, timeout flag and stall counter.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;

    if ((state_q != ERR) && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ERR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and only touches control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
